alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Pipelined execute stage that accepts operand/opcode transactions over a valid/ready handshake.
- Registers each accepted transaction into an issue stage and drives the existing combinational alu from that register.
- Captures result, zero and ovf into an output register and presents them downstream over valid/ready.
- Sits between the register-read/decode logic (upstream) and the writeback logic (downstream). Also tracks illegal opcodes, sticky overflow and a completed-operation count.

Parameters:
- WIDTH, 32, operand/result width; the alu is fixed at 32, so only 32 is supported.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream transaction valid.
- in_ready  out  1  stage can accept a transaction.
- in_op1  in  WIDTH  operand 1, signed.
- in_op2  in  WIDTH  operand 2, signed; shift amount for shift ops.
- in_alu_op  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  WIDTH  alu result.
- out_zero  out  1  result == 0.
- out_ovf  out  1  overflow for this operation.
- out_illegal  out  1  opcode not in the legal set.
- sticky_ovf  out  1  set by any overflow that reaches the output; held until clr_sticky.
- clr_sticky  in  1  synchronous clear of sticky_ovf (and the trap, if enabled).
- op_count  out  CNT_W  completed (output-accepted) transactions; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0) forces the following; all pipeline data registers reset to 0:
  - issue valid = 0 and output valid = 0
  - out_result = 0, out_zero = 0, out_ovf = 0, out_illegal = 0
  - sticky_ovf = 0, op_count = 0
- Legal opcodes:
  - 1000 AND, 1001 OR, 1010 NOR, 1011 NAND, 1100 XOR
  - 0100 ADD, 0101 SUB, 0110 MUL
  - 0000 LSR, 0001 LSL, 0010 ASR, 0011 ASL
- Illegal opcodes: registered result = 0, zero = 1, ovf = 0, illegal = 1.
- Pipeline:
  - Stage 1 (issue) register holds op1/op2/op.
  - Stage 2 (output) register holds result/zero/ovf/illegal.
  - Latency: accept at edge N gives out_valid at edge N+1 (visible in cycle after N+1), assuming no stall.
- Advance rules:
  - s2_load = s1_valid && (!out_valid || out_ready)
  - in_ready = !s1_valid || s2_load; in_ready is combinational from out_ready.
  - Accept = in_valid && in_ready.
- Throughput: one transaction per cycle while out_ready = 1.
- Backpressure: with out_ready = 0, both stages fill, then in_ready = 0. No transaction is dropped or duplicated.
- Stability: out_* is stable while out_valid && !out_ready. Inputs are sampled only on accept.
- op_count increments on out_valid && out_ready and saturates.
- sticky_ovf is set on s2_load when the alu ovf = 1.
  - clr_sticky clears it; a set in the same cycle wins.
- Reset mid-operation discards all in-flight transactions.

Optional Feature:
- Macro: ALU_EXEC_OVF_TRAP_EN.
- Defined: a two-state FSM, RUN and TRAP.
  - RUN goes to TRAP when a transaction with ovf = 1 is loaded into stage 2.
  - In TRAP, in_ready = 0 and stage 1 does not advance. The faulting result still drains normally at the output.
  - TRAP goes to RUN on clr_sticky.
  - Reset goes to RUN.
- Undefined: no FSM; overflow only sets sticky_ovf and never stalls.

Decomposition:
- alu_pkg holds:
  - 4-bit ALUOP_* localparams for the 12 ops above
  - an is_legal_op function
  - the trap state typedef (RUN/TRAP)
- One sub-module: the existing alu, instantiated unchanged and fed from the stage 1 register.
- The handshake and counter logic stays in alu_exec_stage.

Test Plan:
- Single ADD, 100 + 50 with out_ready = 1: out_valid 2 edges after accept; result 0x00000096, zero = 0, ovf = 0, op_count = 1.
- Back-to-back stream with out_ready = 1:
  - SUB 25 − 25 → result 0, zero = 1.
  - MUL 0x00010000 × 0x00010000 → ovf = 1, sticky_ovf = 1.
  - ASR 0xF000000A by 4 → 0xFF000000.
  - One result per cycle, in order.
- Backpressure: 4 transactions issued with out_ready = 0:
  - in_ready drops after 2 accepts.
  - out_result stays held.
  - Releasing out_ready yields all 4 in order with no loss; op_count = 4.
- Illegal op 0111 with operands 5, 7: result 0, zero = 1, out_illegal = 1, ovf = 0.
- ADD 0x7FFFFFFF + 1:
  - Result 0x80000000, ovf = 1.
  - With ALU_EXEC_OVF_TRAP_EN: in_ready stays 0 until clr_sticky pulses, then resumes.
  - Without the macro: no stall.
- Reset mid-stream with 2 transactions in flight: out_valid = 0, sticky_ovf = 0, op_count = 0 immediately. The next accepted op behaves as in the single-ADD test.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, legality check and trap FSM state type for the
// alu execute stage.
package alu_pkg;

  localparam logic [3:0] ALUOP_LSR  = 4'b0000;
  localparam logic [3:0] ALUOP_LSL  = 4'b0001;
  localparam logic [3:0] ALUOP_ASR  = 4'b0010;
  localparam logic [3:0] ALUOP_ASL  = 4'b0011;
  localparam logic [3:0] ALUOP_ADD  = 4'b0100;
  localparam logic [3:0] ALUOP_SUB  = 4'b0101;
  localparam logic [3:0] ALUOP_MUL  = 4'b0110;
  localparam logic [3:0] ALUOP_AND  = 4'b1000;
  localparam logic [3:0] ALUOP_OR   = 4'b1001;
  localparam logic [3:0] ALUOP_NOR  = 4'b1010;
  localparam logic [3:0] ALUOP_NAND = 4'b1011;
  localparam logic [3:0] ALUOP_XOR  = 4'b1100;

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} trap_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALUOP_LSR, ALUOP_LSL, ALUOP_ASR, ALUOP_ASL,
      ALUOP_ADD, ALUOP_SUB, ALUOP_MUL,
      ALUOP_AND, ALUOP_OR, ALUOP_NOR, ALUOP_NAND, ALUOP_XOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit alu. Signed overflow is flagged for ADD, SUB, MUL
// (product does not fit in 32 signed bits) and ASL (bits lost past the sign).
// Shift amount is op2[4:0]. Unknown opcodes give result 0, ovf 0.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  alu_op,
  output logic [31:0] result,
  output logic        zero,
  output logic        ovf
);

  logic [31:0]        sum, diff, shl;
  logic signed [63:0] prod;
  logic [4:0]         amt;

  // Decode the opcode and compute result and overflow
  always_comb begin
    amt    = op2[4:0];
    sum    = op1 + op2;
    diff   = op1 - op2;
    shl    = op1 << amt;
    prod   = $signed({{32{op1[31]}}, op1}) * $signed({{32{op2[31]}}, op2});
    result = '0;
    ovf    = 1'b0;
    case (alu_op)
      ALUOP_AND:  result = op1 & op2;
      ALUOP_OR:   result = op1 | op2;
      ALUOP_NOR:  result = ~(op1 | op2);
      ALUOP_NAND: result = ~(op1 & op2);
      ALUOP_XOR:  result = op1 ^ op2;
      ALUOP_ADD: begin
        result = sum;
        ovf    = (op1[31] == op2[31]) && (sum[31] != op1[31]);
      end
      ALUOP_SUB: begin
        result = diff;
        ovf    = (op1[31] != op2[31]) && (diff[31] != op1[31]);
      end
      ALUOP_MUL: begin
        result = prod[31:0];
        ovf    = prod[63:31] != {33{prod[31]}};
      end
      ALUOP_LSR:  result = op1 >> amt;
      ALUOP_LSL:  result = shl;
      ALUOP_ASR:  result = $signed(op1) >>> amt;
      ALUOP_ASL: begin
        result = shl;
        ovf    = ($signed(shl) >>> amt) != $signed(op1);
      end
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage execute pipeline around alu: issue register (operands/opcode)
// feeding the alu, then an output register presented over valid/ready.
// Tracks illegal opcodes, sticky overflow and a saturating completion count.
// Optional macro ALU_EXEC_OVF_TRAP_EN: an overflow reaching the output register
// freezes the issue stage and input until clr_sticky.
// The alu is fixed at 32 bits, so WIDTH must stay 32.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic [3:0]       in_alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_op1, s1_op2;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero, alu_ovf;
  logic             s1_legal, ovf_eff;
  logic             s2_load, accept, trap;

  alu u_alu (
    .op1    (s1_op1),
    .op2    (s1_op2),
    .alu_op (s1_op),
    .result (alu_result),
    .zero   (alu_zero),
    .ovf    (alu_ovf)
  );

  assign s1_legal = is_legal_op(s1_op);
  assign ovf_eff  = s1_legal && alu_ovf;

`ifdef ALU_EXEC_OVF_TRAP_EN
  trap_state_e state, state_nxt;

  // Trap state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Enter TRAP when an overflowing op moves to the output; leave on clr_sticky
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (s2_load && ovf_eff) state_nxt = TRAP;
      TRAP:    if (clr_sticky)         state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign trap = (state == TRAP);
`else
  assign trap = 1'b0;
`endif

  // in_ready depends combinationally on out_ready through s2_load
  assign s2_load  = s1_valid && !trap && (!out_valid || out_ready);
  assign in_ready = !trap && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;

  // Issue stage: capture inputs only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      s1_op    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op1   <= in_op1;
      s1_op2   <= in_op2;
      s1_op    <= in_alu_op;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Output stage: illegal ops are forced to a zero result with no overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_ovf     <= 1'b0;
      out_illegal <= 1'b0;
    end else if (s2_load) begin
      out_valid   <= 1'b1;
      out_result  <= s1_legal ? alu_result : '0;
      out_zero    <= s1_legal ? alu_zero : 1'b1;
      out_ovf     <= ovf_eff;
      out_illegal <= !s1_legal;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // Sticky overflow: a new overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    sticky_ovf <= 1'b0;
    else if (s2_load && ovf_eff)   sticky_ovf <= 1'b1;
    else if (clr_sticky)           sticky_ovf <= 1'b0;
  end

  // Saturating count of results taken by downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       op_count <= '0;
    else if (out_valid && out_ready && op_count != '1) op_count <= op_count + 1'b1;
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: reset, single op latency, streaming,
// backpressure, illegal op, overflow (with or without ALU_EXEC_OVF_TRAP_EN)
// and reset with transactions in flight.
module tb_alu_exec_stage;

  localparam logic [3:0] OP_LSR = 4'b0000, OP_LSL = 4'b0001, OP_ASR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100, OP_SUB = 4'b0101, OP_MUL = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b1000, OP_OR  = 4'b1001, OP_NAND = 4'b1011;
  localparam logic [3:0] OP_XOR = 4'b1100, OP_BAD = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_op1 = '0, in_op2 = '0;
  logic [3:0]  in_alu_op = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero, out_ovf, out_illegal, sticky_ovf;
  logic        clr_sticky = 1'b0;
  logic [15:0] op_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct packed {
    int          cyc;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        illegal;
  } res_t;
  res_t q[$];

  alu_exec_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_alu_op(in_alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
    .out_illegal(out_illegal), .sticky_ovf(sticky_ovf),
    .clr_sticky(clr_sticky), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake (inputs only change just after posedge)
  always @(negedge clk)
    if (rst_n && out_valid && out_ready)
      q.push_back('{cyc, out_result, out_zero, out_ovf, out_illegal});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic acc = 1'b0;
    in_valid = 1'b1; in_alu_op = op; in_op1 = a; in_op2 = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("send accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 50 && q.size() < n; i++) @(posedge clk);
    #1;
    chk("result count", 32'(q.size()), 32'(n));
  endtask

  function automatic res_t entry(input int i);
    return (i < q.size()) ? q[i] : 'x;
  endfunction

  task automatic chk_res(input string tag, input int i, input logic [31:0] r,
                         input logic z, input logic o, input logic il);
    res_t e = entry(i);
    chk({tag, " result"}, e.result, r);
    chk({tag, " zero"}, 32'(e.zero), 32'(z));
    chk({tag, " ovf"}, 32'(e.ovf), 32'(o));
    chk({tag, " illegal"}, 32'(e.illegal), 32'(il));
  endtask

  task automatic pulse_clr();
    step(); clr_sticky = 1'b1;
    step(); clr_sticky = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ADD 100+50 with out_ready=1; result visible after the second edge
  task automatic single_add(input string tag);
    in_valid = 1'b1; in_alu_op = OP_ADD; in_op1 = 32'd100; in_op2 = 32'd50;
    @(negedge clk); chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    @(negedge clk); chk({tag, " out_valid early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " result"}, out_result, 32'h0000_0096);
    chk({tag, " zero"}, 32'(out_zero), 32'd0);
    chk({tag, " ovf"}, 32'(out_ovf), 32'd0);
    @(negedge clk);
    chk({tag, " op_count"}, 32'(op_count), 32'd1);
    chk({tag, " drained"}, 32'(out_valid), 32'd0);
    step();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_zero", 32'(out_zero), 32'd0);
    chk("rst out_ovf", 32'(out_ovf), 32'd0);
    chk("rst out_illegal", 32'(out_illegal), 32'd0);
    chk("rst sticky", 32'(sticky_ovf), 32'd0);
    chk("rst op_count", 32'(op_count), 32'd0);
    do_reset();
    out_ready = 1'b1;
    step();

    // Single ADD
    single_add("add");

    // Back-to-back stream, one result per cycle in order
    q.delete();
    send(OP_SUB,  32'd25,        32'd25);
    send(OP_ASR,  32'hF000_000A, 32'd4);
    send(OP_NAND, 32'hFFFF_0000, 32'hFF00_FF00);
    send(OP_LSR,  32'h8000_0000, 32'd31);
    send(OP_MUL,  32'h0001_0000, 32'h0001_0000);
    wait_results(5);
    chk_res("sub",  0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    chk_res("asr",  1, 32'hFF00_0000, 1'b0, 1'b0, 1'b0);
    chk_res("nand", 2, 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0);
    chk_res("lsr",  3, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    chk_res("mul",  4, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 5; i++)
      chk("stream spacing", 32'(entry(i).cyc - entry(i-1).cyc), 32'd1);
    @(negedge clk);
    chk("stream sticky", 32'(sticky_ovf), 32'd1);
    chk("stream op_count", 32'(op_count), 32'd6);
`ifdef ALU_EXEC_OVF_TRAP_EN
    chk("mul trap in_ready", 32'(in_ready), 32'd0);
`endif
    pulse_clr();
    @(negedge clk);
    chk("clr sticky", 32'(sticky_ovf), 32'd0);
    chk("clr in_ready", 32'(in_ready), 32'd1);
    step();

    // Illegal opcode
    q.delete();
    send(OP_BAD, 32'd5, 32'd7);
    wait_results(1);
    chk_res("illegal", 0, 32'd0, 1'b1, 1'b0, 1'b1);

    // Signed ADD overflow
    q.delete();
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    wait_results(1);
    chk_res("add ovf", 0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
`ifdef ALU_EXEC_OVF_TRAP_EN
    chk("trap in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("trap held", 32'(in_ready), 32'd0);
    pulse_clr();
    @(negedge clk);
    chk("trap released", 32'(in_ready), 32'd1);
`else
    chk("no stall", 32'(in_ready), 32'd1);
`endif
    step();
    send(OP_OR, 32'h1, 32'h2);

    // Backpressure: two accepts fill the pipe, output held, then drain
    do_reset();
    q.delete();
    out_ready = 1'b0;
    step();
    chk("bp op_count reset", 32'(op_count), 32'd0);
    in_valid = 1'b1; in_alu_op = OP_ADD; in_op1 = 32'd1; in_op2 = 32'd2;
    @(negedge clk); chk("bp accept0", 32'(in_ready), 32'd1);
    step(); in_alu_op = OP_OR; in_op1 = 32'hF0; in_op2 = 32'h0F;
    @(negedge clk); chk("bp accept1", 32'(in_ready), 32'd1);
    step(); in_alu_op = OP_XOR; in_op1 = 32'hFF; in_op2 = 32'h0F;
    @(negedge clk);
    chk("bp in_ready low", 32'(in_ready), 32'd0);
    chk("bp out_valid", 32'(out_valid), 32'd1);
    chk("bp result", out_result, 32'd3);
    repeat (3) step();
    @(negedge clk);
    chk("bp still stalled", 32'(in_ready), 32'd0);
    chk("bp result held", out_result, 32'd3);
    step();
    out_ready = 1'b1;
    send(OP_XOR, 32'hFF, 32'h0F);
    send(OP_LSL, 32'd1, 32'd4);
    wait_results(4);
    repeat (4) step();
    chk("bp no duplicates", 32'(q.size()), 32'd4);
    chk_res("bp0", 0, 32'h03, 1'b0, 1'b0, 1'b0);
    chk_res("bp1", 1, 32'hFF, 1'b0, 1'b0, 1'b0);
    chk_res("bp2", 2, 32'hF0, 1'b0, 1'b0, 1'b0);
    chk_res("bp3", 3, 32'h10, 1'b0, 1'b0, 1'b0);
    chk("bp op_count", 32'(op_count), 32'd4);

    // Reset with two transactions in flight
    out_ready = 1'b0;
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    send(OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    @(negedge clk);
    chk("pre-rst out_valid", 32'(out_valid), 32'd1);
    chk("pre-rst sticky", 32'(sticky_ovf), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", 32'(out_valid), 32'd0);
    chk("mid-rst sticky", 32'(sticky_ovf), 32'd0);
    chk("mid-rst op_count", 32'(op_count), 32'd0);
    chk("mid-rst in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    q.delete();
    single_add("post-rst add");
    chk("post-rst no stale", 32'(q.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
